// File: rtl/lsu_axi_master_pkg.sv
// Shared definitions for the load/store unit AXI master: access-type codes,
// AXI size/response codes, FSM state type and small op-decode helpers.
package lsu_axi_master_pkg;

    // Access-type encoding driven by the memory stage.
    localparam logic [3:0] MEM_NO_RW = 4'd0;
    localparam logic [3:0] MEM_LB    = 4'd1;
    localparam logic [3:0] MEM_LH    = 4'd2;
    localparam logic [3:0] MEM_LW    = 4'd3;
    localparam logic [3:0] MEM_LBU   = 4'd4;
    localparam logic [3:0] MEM_LHU   = 4'd5;
    localparam logic [3:0] MEM_SB    = 4'd6;
    localparam logic [3:0] MEM_SH    = 4'd7;
    localparam logic [3:0] MEM_SW    = 4'd8;

    // AXI AxSIZE encodings.
    localparam logic [2:0] SIZE_B = 3'd0;
    localparam logic [2:0] SIZE_H = 3'd1;
    localparam logic [2:0] SIZE_W = 3'd2;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_DONE
    } lsu_state_e;

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic [2:0] op_size(input logic [3:0] op);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return SIZE_H;
            MEM_LW, MEM_SW:          return SIZE_W;
            default:                 return SIZE_B;
        endcase
    endfunction

    // Halves must sit on even addresses, words on multiples of four.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        case (op_size(op))
            SIZE_H:  return addr_lo[0];
            SIZE_W:  return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_axi_master_lane_align.sv
// Combinational byte-lane steering between the 32-bit pipeline view and the
// DATA_W-wide AXI data bus: store strobes/data and load extraction/extension.
module lsu_lane_align
    import lsu_axi_master_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic [3:0]        op_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [31:0]       st_data_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic [STRB_W-1:0] bus_wstrb_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    output logic [31:0]       ld_data_o
);

    logic [STRB_W-1:0] base_strb;
    logic [DATA_W-1:0] rep_data;
    logic [31:0]       lane;

    // Store side: the value is replicated on every lane so the slave can pick
    // it from whichever lane the strobes select; non-stores drive nothing.
    always_comb begin
        base_strb = '0;
        rep_data  = '0;
        case (op_size(op_i))
            SIZE_B: begin
                base_strb = STRB_W'(4'h1);
                rep_data  = {STRB_W{st_data_i[7:0]}};
            end
            SIZE_H: begin
                base_strb = STRB_W'(4'h3);
                rep_data  = {(STRB_W/2){st_data_i[15:0]}};
            end
            default: begin
                base_strb = STRB_W'(4'hF);
                rep_data  = {(STRB_W/4){st_data_i}};
            end
        endcase
        bus_wstrb_o = '0;
        bus_wdata_o = '0;
        if (op_is_store(op_i)) begin
            bus_wstrb_o = base_strb << off_i;
            bus_wdata_o = rep_data;
        end
    end

    assign lane = 32'(bus_rdata_i >> {off_i, 3'b000});

    // Load side: shift the addressed lane down, then sign/zero extend.
    always_comb begin
        case (op_i)
            MEM_LB:  ld_data_o = {{24{lane[7]}}, lane[7:0]};
            MEM_LBU: ld_data_o = {24'h0, lane[7:0]};
            MEM_LH:  ld_data_o = {{16{lane[15]}}, lane[15:0]};
            MEM_LHU: ld_data_o = {16'h0, lane[15:0]};
            MEM_LW:  ld_data_o = lane;
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_axi_master.sv
// Load/store unit bus master: one memory-stage request becomes one AXI4-Lite
// write (AW/W/B) or read (AR/R) transaction, answered by a single-cycle
// response pulse carrying extended load data and an error flag.
//
// state | meaning
// IDLE  | ready for a request
// WADDR | AW and W offered, each retired on its own handshake
// WRESP | waiting for the write response
// RADDR | AR offered
// RDATA | waiting for read data
// DONE  | one-cycle response pulse
module lsu_axi_master
    import lsu_axi_master_pkg::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              io_master_awvalid,
    input  logic              io_master_awready,
    output logic [ADDR_W-1:0] io_master_awaddr,
    output logic [2:0]        io_master_awsize,
    output logic              io_master_wvalid,
    input  logic              io_master_wready,
    output logic [DATA_W-1:0] io_master_wdata,
    output logic [STRB_W-1:0] io_master_wstrb,
    input  logic              io_master_bvalid,
    output logic              io_master_bready,
    input  logic [1:0]        io_master_bresp,
    output logic              io_master_arvalid,
    input  logic              io_master_arready,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic [2:0]        io_master_arsize,
    input  logic              io_master_rvalid,
    output logic              io_master_rready,
    input  logic [DATA_W-1:0] io_master_rdata,
    input  logic [1:0]        io_master_rresp
);

    localparam int OFF_W = $clog2(STRB_W);

    lsu_state_e        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       st_data_q, st_data_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       ld_data;

    lsu_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .op_i        (op_q),
        .off_i       (addr_q[OFF_W-1:0]),
        .st_data_i   (st_data_q),
        .bus_rdata_i (io_master_rdata),
        .bus_wstrb_o (io_master_wstrb),
        .bus_wdata_o (io_master_wdata),
        .ld_data_o   (ld_data)
    );

    assign io_master_awaddr = addr_q;
    assign io_master_araddr = addr_q;
    // op_q clears to no-op on reset, so both sizes read zero there.
    assign io_master_awsize = op_is_store(op_q) ? op_size(op_q) : 3'd0;
    assign io_master_arsize = op_is_load(op_q)  ? op_size(op_q) : 3'd0;
    assign resp_rdata       = (state_q == ST_DONE) ? rdata_q : 32'h0;
    assign resp_err         = (state_q == ST_DONE) && err_q;

    // Next-state, handshake bookkeeping and channel valid/ready outputs.
    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        addr_d            = addr_q;
        st_data_d         = st_data_q;
        aw_done_d         = aw_done_q;
        w_done_d          = w_done_q;
        rdata_d           = rdata_q;
        err_d             = err_q;
        req_ready         = 1'b0;
        resp_valid        = 1'b0;
        io_master_awvalid = 1'b0;
        io_master_wvalid  = 1'b0;
        io_master_bready  = 1'b0;
        io_master_arvalid = 1'b0;
        io_master_rready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && (op_is_store(req_op) || op_is_load(req_op))) begin
                    op_d      = req_op;
                    addr_d    = req_addr;
                    st_data_d = req_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rdata_d   = 32'h0;
                    err_d     = 1'b0;
                    if (op_misaligned(req_op, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (op_is_store(req_op)) begin
                        state_d = ST_WADDR;
                    end else begin
                        state_d = ST_RADDR;
                    end
                end
            end
            ST_WADDR: begin
                io_master_awvalid = !aw_done_q;
                io_master_wvalid  = !w_done_q;
                if (io_master_awvalid && io_master_awready) aw_done_d = 1'b1;
                if (io_master_wvalid && io_master_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d) state_d = ST_WRESP;
            end
            ST_WRESP: begin
                io_master_bready = 1'b1;
                if (io_master_bvalid) begin
                    err_d   = io_master_bresp != RESP_OKAY;
                    state_d = ST_DONE;
                end
            end
            ST_RADDR: begin
                io_master_arvalid = 1'b1;
                if (io_master_arready) state_d = ST_RDATA;
            end
            ST_RDATA: begin
                io_master_rready = 1'b1;
                if (io_master_rvalid) begin
                    err_d   = io_master_rresp != RESP_OKAY;
                    rdata_d = (io_master_rresp == RESP_OKAY) ? ld_data : 32'h0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= MEM_NO_RW;
            addr_q    <= '0;
            st_data_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            st_data_q <= st_data_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: a 32-bit instance behind a configurable-latency
// slave with a response scoreboard, plus a 64-bit instance behind an
// always-ready slave for wide-bus lane placement.
module tb_lsu_axi_master;
    import lsu_axi_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = MEM_NO_RW;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        io_master_awvalid, io_master_awready = 1'b0;
    logic [31:0] io_master_awaddr;
    logic [2:0]  io_master_awsize;
    logic        io_master_wvalid, io_master_wready = 1'b0;
    logic [31:0] io_master_wdata;
    logic [3:0]  io_master_wstrb;
    logic        io_master_bvalid = 1'b0, io_master_bready;
    logic [1:0]  io_master_bresp = 2'b00;
    logic        io_master_arvalid, io_master_arready = 1'b0;
    logic [31:0] io_master_araddr;
    logic [2:0]  io_master_arsize;
    logic        io_master_rvalid = 1'b0, io_master_rready;
    logic [31:0] io_master_rdata = '0;
    logic [1:0]  io_master_rresp = 2'b00;

    logic        w_req_valid = 1'b0, w_req_ready;
    logic [3:0]  w_req_op = MEM_NO_RW;
    logic [31:0] w_req_addr = '0, w_req_wdata = '0;
    logic        w_resp_valid, w_resp_err;
    logic [31:0] w_resp_rdata;
    logic        w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
    logic [31:0] w_awaddr, w_araddr;
    logic [2:0]  w_awsize, w_arsize;
    logic [63:0] w_wdata;
    logic [7:0]  w_wstrb;
    logic [63:0] w_rdata = '0;

    int n_chk  = 0;
    int n_pass = 0;
    logic [32:0] sb_q[$];
    logic [32:0] sb_exp;

    always #5 clk = ~clk;

    lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
        .io_master_awaddr(io_master_awaddr), .io_master_awsize(io_master_awsize),
        .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
        .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
        .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
        .io_master_bresp(io_master_bresp),
        .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
        .io_master_araddr(io_master_araddr), .io_master_arsize(io_master_arsize),
        .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
        .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp)
    );

    lsu_axi_master #(.ADDR_W(32), .DATA_W(64)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_op(w_req_op),
        .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata), .resp_err(w_resp_err),
        .io_master_awvalid(w_awvalid), .io_master_awready(1'b1),
        .io_master_awaddr(w_awaddr), .io_master_awsize(w_awsize),
        .io_master_wvalid(w_wvalid), .io_master_wready(1'b1),
        .io_master_wdata(w_wdata), .io_master_wstrb(w_wstrb),
        .io_master_bvalid(1'b1), .io_master_bready(w_bready),
        .io_master_bresp(2'b00),
        .io_master_arvalid(w_arvalid), .io_master_arready(1'b1),
        .io_master_araddr(w_araddr), .io_master_arsize(w_arsize),
        .io_master_rvalid(1'b1), .io_master_rready(w_rready),
        .io_master_rdata(w_rdata), .io_master_rresp(2'b00)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    endtask

    // Response scoreboard for the 32-bit instance.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("resp_rdata", 64'(resp_rdata), 64'(sb_exp[31:0]));
                chk("resp_err", 64'(resp_err), 64'(sb_exp[32]));
            end
        end
    end

    // One access on the 32-bit instance; slave waits the given number of
    // cycles after each valid/ready before answering. Call at posedge+1.
    task automatic run_xfer(
        input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
        input int aw_dly, input int w_dly, input int ar_dly, input int rsp_dly,
        input logic [1:0] rsp, input logic [31:0] rd_bus,
        input logic [2:0] exp_size, input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
        input logic exp_err, input logic [31:0] exp_rdata,
        input int exp_lat, input int exp_aw_last, input int exp_w_last, input logic exp_bus);
        int awcnt = 0, wcnt = 0, arcnt = 0, rspcnt = 0;
        int lat = -1, aw_last = -1, w_last = -1;
        logic aw_seen = 1'b0, w_seen = 1'b0, ar_seen = 1'b0, seen = 1'b0;
        sb_q.push_back({exp_err, exp_rdata});
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = MEM_NO_RW;
        for (int c = 1; c <= 40 && !seen; c++) begin
            io_master_awready = io_master_awvalid && (awcnt >= aw_dly);
            if (io_master_awvalid) awcnt++;
            io_master_wready = io_master_wvalid && (wcnt >= w_dly);
            if (io_master_wvalid) wcnt++;
            io_master_arready = io_master_arvalid && (arcnt >= ar_dly);
            if (io_master_arvalid) arcnt++;
            io_master_bvalid = io_master_bready && (rspcnt >= rsp_dly);
            io_master_rvalid = io_master_rready && (rspcnt >= rsp_dly);
            if (io_master_bready || io_master_rready) rspcnt++;
            io_master_bresp = rsp; io_master_rresp = rsp; io_master_rdata = rd_bus;
            @(negedge clk);
            if (c == 1) chk("req_ready_busy", 64'(req_ready), 64'd0);
            if (io_master_awvalid) begin
                aw_last = c;
                if (!aw_seen) begin
                    aw_seen = 1'b1;
                    chk("awaddr", 64'(io_master_awaddr), 64'(addr));
                    chk("awsize", 64'(io_master_awsize), 64'(exp_size));
                end
            end
            if (io_master_wvalid) begin
                w_last = c;
                if (!w_seen) begin
                    w_seen = 1'b1;
                    chk("wstrb", 64'(io_master_wstrb), 64'(exp_strb));
                    chk("wdata", 64'(io_master_wdata), 64'(exp_wdata));
                end
            end
            if (io_master_arvalid && !ar_seen) begin
                ar_seen = 1'b1;
                chk("araddr", 64'(io_master_araddr), 64'(addr));
                chk("arsize", 64'(io_master_arsize), 64'(exp_size));
            end
            if (resp_valid) begin seen = 1'b1; lat = c; end
            @(posedge clk); #1;
        end
        io_master_awready = 1'b0; io_master_wready = 1'b0; io_master_arready = 1'b0;
        io_master_bvalid = 1'b0; io_master_rvalid = 1'b0;
        chk("latency", 64'(lat), 64'(exp_lat));
        if (exp_aw_last >= 0) chk("awvalid_last", 64'(aw_last), 64'(exp_aw_last));
        if (exp_w_last >= 0)  chk("wvalid_last", 64'(w_last), 64'(exp_w_last));
        if (!exp_bus) chk("no_bus_activity", 64'({aw_seen, w_seen, ar_seen}), 64'd0);
    endtask

    // One access on the 64-bit instance (always-ready slave, fixed c3 response).
    task automatic run64(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [7:0] exp_strb, input logic [63:0] exp_wdata,
                         input logic [2:0] exp_size, input logic [31:0] exp_rdata);
        w_req_valid = 1'b1; w_req_op = op; w_req_addr = addr; w_req_wdata = wd;
        @(posedge clk); #1;
        w_req_valid = 1'b0; w_req_op = MEM_NO_RW;
        @(negedge clk);
        if (op_is_store(op)) begin
            chk("w64_awvalid", 64'(w_awvalid), 64'd1);
            chk("w64_awsize", 64'(w_awsize), 64'(exp_size));
            chk("w64_wstrb", 64'(w_wstrb), 64'(exp_strb));
            chk("w64_wdata", w_wdata, exp_wdata);
        end else begin
            chk("w64_arvalid", 64'(w_arvalid), 64'd1);
            chk("w64_arsize", 64'(w_arsize), 64'(exp_size));
            chk("w64_araddr", 64'(w_araddr), 64'(addr));
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("w64_resp_valid", 64'(w_resp_valid), 64'd1);
        chk("w64_resp_rdata", 64'(w_resp_rdata), 64'(exp_rdata));
        chk("w64_resp_err", 64'(w_resp_err), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_ctl", 64'({io_master_awvalid, io_master_wvalid, io_master_bready,
                            io_master_arvalid, io_master_rready, resp_valid, resp_err}), 64'd0);
        chk("rst_bus", 64'({io_master_wstrb, io_master_wdata, io_master_awsize, io_master_arsize}), 64'd0);
        chk("rst_rdata", 64'(resp_rdata), 64'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;

        //       op       addr          wdata         aw w ar rsp rsp    rd_bus        size    strb  exp_wdata     err   rdata          lat awl wl bus
        run_xfer(MEM_SB,  32'h1000_0003, 32'h0000_00A5, 0, 0, 0, 0, 2'b00, 32'h0,         SIZE_B, 4'h8, 32'hA5A5_A5A5, 1'b0, 32'h0,          3, 1, 1, 1'b1);
        run_xfer(MEM_SH,  32'h1000_0002, 32'hFFFF_1234, 0, 0, 0, 0, 2'b00, 32'h0,         SIZE_H, 4'hC, 32'h1234_1234, 1'b0, 32'h0,          3, 1, 1, 1'b1);
        run_xfer(MEM_SW,  32'h2000_0000, 32'hDEAD_BEEF, 0, 0, 0, 0, 2'b00, 32'h0,         SIZE_W, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0,          3, 1, 1, 1'b1);
        run_xfer(MEM_LB,  32'h0000_0002, 32'h0,         0, 0, 0, 0, 2'b00, 32'h0080_0000, SIZE_B, 4'h0, 32'h0,         1'b0, 32'hFFFF_FF80,  3, -1, -1, 1'b1);
        run_xfer(MEM_LBU, 32'h0000_0002, 32'h0,         0, 0, 0, 0, 2'b00, 32'h0080_0000, SIZE_B, 4'h0, 32'h0,         1'b0, 32'h0000_0080,  3, -1, -1, 1'b1);
        run_xfer(MEM_LH,  32'h0000_0002, 32'h0,         0, 0, 2, 1, 2'b00, 32'h8001_0000, SIZE_H, 4'h0, 32'h0,         1'b0, 32'hFFFF_8001,  6, -1, -1, 1'b1);
        run_xfer(MEM_LHU, 32'h0000_0002, 32'h0,         0, 0, 0, 0, 2'b00, 32'h8001_0000, SIZE_H, 4'h0, 32'h0,         1'b0, 32'h0000_8001,  3, -1, -1, 1'b1);
        run_xfer(MEM_LW,  32'h0000_0004, 32'h0,         0, 0, 0, 0, 2'b00, 32'hCAFE_F00D, SIZE_W, 4'h0, 32'h0,         1'b0, 32'hCAFE_F00D,  3, -1, -1, 1'b1);
        run_xfer(MEM_SW,  32'h3000_0010, 32'h0BAD_F00D, 3, 0, 0, 0, 2'b00, 32'h0,         SIZE_W, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0,          6, 4, 1, 1'b1);
        run_xfer(MEM_SB,  32'h3000_0011, 32'h0000_0042, 0, 2, 0, 0, 2'b00, 32'h0,         SIZE_B, 4'h2, 32'h4242_4242, 1'b0, 32'h0,          5, 1, 3, 1'b1);
        run_xfer(MEM_SH,  32'h3000_0000, 32'h0000_5566, 0, 0, 0, 2, 2'b10, 32'h0,         SIZE_H, 4'h3, 32'h5566_5566, 1'b1, 32'h0,          5, 1, 1, 1'b1);
        run_xfer(MEM_LW,  32'h4000_0002, 32'h0,         0, 0, 0, 0, 2'b00, 32'h0,         SIZE_W, 4'h0, 32'h0,         1'b1, 32'h0,          1, -1, -1, 1'b0);
        run_xfer(MEM_LH,  32'h4000_0001, 32'h0,         0, 0, 0, 0, 2'b00, 32'h0,         SIZE_H, 4'h0, 32'h0,         1'b1, 32'h0,          1, -1, -1, 1'b0);
        run_xfer(MEM_SW,  32'h4000_0003, 32'h1111_1111, 0, 0, 0, 0, 2'b00, 32'h0,         SIZE_W, 4'h0, 32'h0,         1'b1, 32'h0,          1, -1, -1, 1'b0);
        run_xfer(MEM_LW,  32'h5000_0000, 32'h0,         0, 0, 0, 0, 2'b10, 32'h1234_5678, SIZE_W, 4'h0, 32'h0,         1'b1, 32'h0,          3, -1, -1, 1'b1);

        // No-op requests are ignored: no bus traffic, no response, stays ready.
        req_valid = 1'b1; req_op = MEM_NO_RW; req_addr = 32'h6000_0000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("no_rw_ready", 64'(req_ready), 64'd1);
        chk("no_rw_bus", 64'({io_master_awvalid, io_master_wvalid, io_master_arvalid}), 64'd0);
        @(posedge clk); #1;

        // Reset while waiting in RDATA aborts with no response.
        req_valid = 1'b1; req_op = MEM_LW; req_addr = 32'h7000_0040;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = MEM_NO_RW;
        io_master_arready = 1'b1;
        @(posedge clk); #1;
        io_master_arready = 1'b0;
        @(negedge clk);
        chk("abort_rready_pre", 64'(io_master_rready), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_ctl", 64'({io_master_rready, io_master_arvalid, io_master_awvalid, resp_valid, resp_err}), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd1);
        chk("abort_rdata", 64'(resp_rdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        w_rdata = 64'h1234_5678_9ABC_DEF0;
        run64(MEM_SH, 32'h8000_0006, 32'h0000_BEEF, 8'hC0, 64'hBEEF_BEEF_BEEF_BEEF, SIZE_H, 32'h0);
        run64(MEM_LW, 32'h8000_0004, 32'h0,         8'h00, 64'h0,                   SIZE_W, 32'h1234_5678);
        run64(MEM_LH, 32'h8000_0002, 32'h0,         8'h00, 64'h0,                   SIZE_H, 32'hFFFF_9ABC);
        run64(MEM_LBU, 32'h8000_0007, 32'h0,        8'h00, 64'h0,                   SIZE_B, 32'h0000_0012);

        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
- Parametrised successor to the memory-stage store path: one load/store unit driving a full AXI4-Lite-style master (AW/W/B and AR/R) for every access.
- Takes one request per transaction from the memory stage.
- Generates lane-aligned wstrb/wdata and correct AXI size, and holds until the bus handshakes complete.
- Returns sign- or zero-extended load data with an error flag. Sits between pipeline regM and the SoC interconnect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, AXI data bus width; legal values 32 or 64.
- STRB_W, DATA_W/8, derived; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  access request from memory stage
- req_ready  out  1  unit idle, request accepted this cycle when high with req_valid
- req_op  in  4  access type, `mem_rw_*` encoding from define.v
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, value in low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access or non-OKAY bresp/rresp
- io_master_awvalid  out  1  write address valid
- io_master_awready  in  1  write address ready
- io_master_awaddr  out  ADDR_W  write address
- io_master_awsize  out  3  write size
- io_master_wvalid  out  1  write data valid
- io_master_wready  in  1  write data ready
- io_master_wdata  out  DATA_W  write data
- io_master_wstrb  out  STRB_W  write byte strobes
- io_master_bvalid  in  1  write response valid
- io_master_bready  out  1  write response ready
- io_master_bresp  in  2  write response code
- io_master_arvalid  out  1  read address valid
- io_master_arready  in  1  read address ready
- io_master_araddr  out  ADDR_W  read address
- io_master_arsize  out  3  read size
- io_master_rvalid  in  1  read data valid
- io_master_rready  out  1  read data ready
- io_master_rdata  in  DATA_W  read data
- io_master_rresp  in  2  read response code

Behaviour:

Reset:
- All outputs 0 except req_ready=1; FSM returns to IDLE.
- rst mid-transaction aborts immediately. No resp_valid is emitted for the aborted access.

FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, DONE.

IDLE:
- req_ready=1.
- On req_valid with req_op = `mem_no_rw`: ignored, no response.
- Otherwise register op, addr and data. Misalignment is checked first:
  - half access with addr[0]!=0, or word access with addr[1:0]!=0 -> DONE with resp_err=1, no bus activity.
  - stores -> WADDR; loads -> RADDR.

WADDR:
- awvalid and wvalid are asserted in the cycle after acceptance.
- Each valid drops independently on its own handshake (valid&ready). Both are held stable until then.
- When both have handshaked (same or different cycles) -> WRESP.

WRESP:
- bready=1.
- On bvalid -> DONE; resp_err = (bresp!=0).

RADDR:
- arvalid held until arready -> RDATA.

RDATA:
- rready=1.
- On rvalid, capture the extracted data -> DONE; resp_err = (rresp!=0).

DONE:
- resp_valid=1 for exactly one cycle, then IDLE.
- req_ready=0 in every state except IDLE.

Address and size:
- awaddr/araddr = full byte address, unmodified.
- awsize/arsize: 0 for byte, 1 for half, 2 for word (AXI encoding).

Write lane generation:
- off = addr[log2(STRB_W)-1:0].
- wstrb = base mask (0x1/0x3/0xF) << off.
- wdata = req_wdata masked to access size, replicated across all lanes.

Read extraction:
- lane = rdata >> (off*8).
- lb/lh sign-extend bits 7/15; lbu/lhu zero-extend; lw passes 32 bits through.

Latency (zero-wait slave):
- store: accept c0, AW/W c1, B c2, resp_valid c3.
- load: accept c0, AR c1, R c2, resp_valid c3.
- Misaligned access: resp_valid at c1.

Decomposition:
- `mem_rw_*` codes, AXI size codes (SIZE_B/H/W) and RESP_OKAY live in shared define.v / package.
- One natural sub-module, lsu_lane_align: purely combinational wstrb/wdata generation and rdata extraction. Parametrised by DATA_W, instantiated once.

Test Plan:
- sb 0xA5 to addr 0x1000_0003, DATA_W=32, zero-wait slave:
  - wstrb=0x8, wdata=0xA5A5A5A5, awsize=0.
  - resp_valid at c3, err=0.
- sh to 0x8000_0006, DATA_W=64: wstrb=0xC0, awsize=1.
- lb at 0x2, rdata=0x0080_0000 -> resp_rdata=0xFFFF_FF80; lbu same -> 0x0000_0080.
- Independent channel handshakes:
  - awready delayed 3 cycles, wready immediate -> wvalid drops after c1, awvalid held to c4.
  - bready rises c5, response one cycle after bvalid.
- lw at 0x...2 -> resp_valid c1, resp_err=1, no AR/AW valid ever asserted.
- rresp=2 (SLVERR) -> resp_err=1.
- rst asserted while in RDATA -> outputs zero immediately, req_ready=1, no resp_valid.
